// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_w(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake bundle plus FIFO write side, as seen by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      f_full;
  logic [DATA_W-1:0]         data_in;
  logic                      wr_en;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;

  modport master (
    output req_valid, req_data, f_full,
    input  req_ready, data_in, wr_en, grant, busy
  );

  modport slave (
    input  req_valid, req_data, f_full,
    output req_ready, data_in, wr_en, grant, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: the lowest index after i_ptr wins,
// with i_ptr itself considered last.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int SRC_W = src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [SRC_W-1:0]   o_idx
);

  int w_best_d;
  int w_d;

  always_comb begin
    o_any    = |i_req;
    o_idx    = '0;
    w_best_d = NUM_REQ;
    w_d      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Distance from the pointer, 0 for ptr+1 up to NUM_REQ-1 for ptr itself.
      w_d = (i + 2 * NUM_REQ - int'(i_ptr) - 1) % NUM_REQ;
      if (i_req[i] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        o_idx    = SRC_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: one owner at a time, bursts of up to
// MAX_BURST beats, zero-latency pass-through of the owner's beat to the FIFO.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int SRC_W  = src_w(NUM_REQ);
  localparam int BEAT_W = beat_w(MAX_BURST);
  localparam logic [0:0]        S_IDLE    = 1'(ARB_IDLE);
  localparam logic [0:0]        S_BUSY    = 1'(ARB_BUSY);
  localparam logic [SRC_W-1:0]  RR_INIT   = SRC_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  logic [0:0]        r_state;
  logic [SRC_W-1:0]  r_owner;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [BEAT_W-1:0] r_beat_cnt;

  logic               w_busy;
  logic               w_owner_vld;
  logic [DATA_W-1:0]  w_owner_data;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_accept;
  logic               w_xfer;
  logic               w_release;
  logic [SRC_W-1:0]   w_pick_ptr;
  logic               w_pick_any;
  logic [SRC_W-1:0]   w_pick_idx;

  always_comb begin
    w_owner_vld  = 1'b0;
    w_owner_data = '0;
    w_owner_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == SRC_W'(i)) begin
        w_owner_vld   = bus.req_valid[i];
        w_owner_data  = bus.req_data[i*DATA_W +: DATA_W];
        w_owner_oh[i] = 1'b1;
      end
    end
  end

  assign w_busy    = (r_state == S_BUSY);
  // Gating with rst keeps a beat from being accepted on the edge that aborts the grant.
  assign w_accept  = w_busy & ~bus.f_full & ~rst;
  assign w_xfer    = w_accept & w_owner_vld;
  assign w_release = w_busy & ((w_xfer & (r_beat_cnt == LAST_BEAT)) | ~w_owner_vld);

  // On release the pointer moves to the owner, so the same picker serves both paths.
  assign w_pick_ptr = w_busy ? r_owner : r_rr_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (w_pick_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  assign bus.req_ready = w_accept ? w_owner_oh : '0;
  assign bus.wr_en     = w_xfer;
  assign bus.grant     = w_busy ? w_owner_oh : '0;
  assign bus.busy      = w_busy;
  assign bus.data_in   = w_busy ? w_owner_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= RR_INIT;
      r_beat_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_pick_any) begin
        r_state    <= S_BUSY;
        r_owner    <= w_pick_idx;
        r_beat_cnt <= '0;
      end
    end else if (w_release) begin
      r_rr_ptr   <= r_owner;
      r_beat_cnt <= '0;
      if (w_pick_any) begin
        r_owner <= w_pick_idx;
      end else begin
        r_state <= S_IDLE;
      end
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, rotation, re-grant, full stall,
// owner drop and reset during a burst.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [5:0] seq [4];

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) ifc ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Producer i presents {i, sequence number}; the number advances on acceptance.
  always_comb begin
    ifc.req_data = '0;
    for (int i = 0; i < 4; i++) ifc.req_data[i*8 +: 8] = {2'(i), seq[i]};
  end

  task automatic advance();
    logic [3:0] acc;
    acc = ifc.req_ready & ifc.req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) seq[i] = seq[i] + 6'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.req_valid = '0;
    ifc.f_full = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.req_valid = 4'hF;
    ifc.f_full = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", ifc.grant); end
    checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", ifc.busy); end
    checks++; if (ifc.wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", ifc.wr_en); end
    checks++; if (ifc.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", ifc.req_ready); end
    checks++; if (ifc.data_in !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", ifc.data_in); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b0000 || ifc.wr_en !== 1'b0) begin failures++; $display("FAIL idle_cycle grant=%b wr_en=%b exp=0000/0", ifc.grant, ifc.wr_en); end
    advance();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (ifc.grant !== 4'b0001 || ifc.wr_en !== 1'b1) begin failures++; $display("FAIL first_burst_%0d grant=%b wr_en=%b exp=0001/1", k, ifc.grant, ifc.wr_en); end
      checks++; if (ifc.data_in !== 8'(k)) begin failures++; $display("FAIL first_burst_data_%0d got=%h exp=%h", k, ifc.data_in, 8'(k)); end
      advance();
    end
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b0010 || ifc.wr_en !== 1'b1) begin failures++; $display("FAIL no_bubble grant=%b wr_en=%b exp=0010/1", ifc.grant, ifc.wr_en); end
    checks++; if (ifc.data_in !== 8'h40) begin failures++; $display("FAIL no_bubble_data got=%h exp=40", ifc.data_in); end
    ifc.req_valid = '0;
  endtask

  task automatic test_round_robin();
    int beats;
    int eo;
    int cnt [4];
    logic [5:0] exp_seq [4];
    logic [3:0] exp_g;
    beats = 0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; exp_seq[i] = '0; end
    do_reset();
    ifc.req_valid = 4'hF;
    for (int c = 0; c < 65; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (ifc.wr_en !== 1'b0) begin failures++; $display("FAIL rr_idle wr_en=%b exp=0", ifc.wr_en); end
      end else begin
        checks++; if (ifc.wr_en !== 1'b1) begin failures++; $display("FAIL rr_wr_en cycle=%0d got=%b exp=1", c, ifc.wr_en); end
        if (ifc.wr_en === 1'b1) begin
          eo = (beats / 4) % 4;
          exp_g = 4'b0001 << eo;
          checks++; if (ifc.grant !== exp_g) begin failures++; $display("FAIL rr_grant beat=%0d got=%b exp=%b", beats, ifc.grant, exp_g); end
          checks++; if (ifc.data_in !== {2'(eo), exp_seq[eo]}) begin failures++; $display("FAIL rr_data beat=%0d got=%h exp=%h", beats, ifc.data_in, {2'(eo), exp_seq[eo]}); end
          exp_seq[eo] = exp_seq[eo] + 6'd1;
          cnt[eo]++;
          beats++;
        end
      end
      advance();
    end
    checks++; if (beats != 64) begin failures++; $display("FAIL rr_beats got=%0d exp=64", beats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seq[i] !== 6'd16) begin failures++; $display("FAIL rr_accepted_%0d got=%0d exp=16", i, seq[i]); end
    end
    ifc.req_valid = '0;
  endtask

  task automatic test_single_req();
    do_reset();
    ifc.req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (ifc.wr_en !== 1'b0) begin failures++; $display("FAIL single_idle wr_en=%b exp=0", ifc.wr_en); end
    advance();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (ifc.grant !== 4'b0100 || ifc.wr_en !== 1'b1) begin failures++; $display("FAIL single_beat_%0d grant=%b wr_en=%b exp=0100/1", k, ifc.grant, ifc.wr_en); end
      checks++; if (ifc.data_in !== 8'(8'h80 + k)) begin failures++; $display("FAIL single_data_%0d got=%h exp=%h", k, ifc.data_in, 8'(8'h80 + k)); end
      advance();
    end
    ifc.req_valid = '0;
    @(negedge clk);
    checks++; if (ifc.wr_en !== 1'b0) begin failures++; $display("FAIL single_drop wr_en=%b exp=0", ifc.wr_en); end
    advance();
    ifc.req_valid = 4'b1011;
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b0000) begin failures++; $display("FAIL single_idle2 grant=%b exp=0000", ifc.grant); end
    advance();
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b1000 || ifc.data_in !== 8'hC0) begin failures++; $display("FAIL single_ptr grant=%b data=%h exp=1000/c0", ifc.grant, ifc.data_in); end
    ifc.req_valid = '0;
  endtask

  task automatic test_full_stall();
    do_reset();
    ifc.req_valid = 4'b0010;
    @(negedge clk);
    advance();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (ifc.wr_en !== 1'b1 || ifc.data_in !== 8'(8'h40 + k)) begin failures++; $display("FAIL full_pre_%0d wr_en=%b data=%h exp=1/%h", k, ifc.wr_en, ifc.data_in, 8'(8'h40 + k)); end
      advance();
    end
    ifc.f_full = 1'b1;
    ifc.req_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (ifc.wr_en !== 1'b0 || ifc.req_ready !== 4'b0000) begin failures++; $display("FAIL full_stall_%0d wr_en=%b ready=%b exp=0/0000", k, ifc.wr_en, ifc.req_ready); end
      checks++; if (ifc.grant !== 4'b0010) begin failures++; $display("FAIL full_grant_%0d got=%b exp=0010", k, ifc.grant); end
      advance();
    end
    ifc.f_full = 1'b0;
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      checks++; if (ifc.wr_en !== 1'b1 || ifc.grant !== 4'b0010 || ifc.data_in !== 8'(8'h40 + k)) begin failures++; $display("FAIL full_post_%0d wr_en=%b grant=%b data=%h exp=1/0010/%h", k, ifc.wr_en, ifc.grant, ifc.data_in, 8'(8'h40 + k)); end
      advance();
    end
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b0001 || ifc.wr_en !== 1'b1 || ifc.data_in !== 8'h00) begin failures++; $display("FAIL full_release grant=%b wr_en=%b data=%h exp=0001/1/00", ifc.grant, ifc.wr_en, ifc.data_in); end
    ifc.req_valid = '0;
  endtask

  task automatic test_owner_drop();
    do_reset();
    ifc.req_valid = 4'b1001;
    @(negedge clk);
    advance();
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b0001 || ifc.wr_en !== 1'b1 || ifc.data_in !== 8'h00) begin failures++; $display("FAIL drop_first grant=%b wr_en=%b data=%h exp=0001/1/00", ifc.grant, ifc.wr_en, ifc.data_in); end
    advance();
    ifc.req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (ifc.wr_en !== 1'b0) begin failures++; $display("FAIL drop_cycle wr_en=%b exp=0", ifc.wr_en); end
    advance();
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b1000 || ifc.wr_en !== 1'b1 || ifc.data_in !== 8'hC0) begin failures++; $display("FAIL drop_next grant=%b wr_en=%b data=%h exp=1000/1/c0", ifc.grant, ifc.wr_en, ifc.data_in); end
    checks++; if (seq[0] !== 6'd1) begin failures++; $display("FAIL drop_req0_beats got=%0d exp=1", seq[0]); end
    ifc.req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ifc.req_valid = 4'hF;
    @(negedge clk);
    advance();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (ifc.wr_en !== 1'b1 || ifc.data_in !== 8'(k)) begin failures++; $display("FAIL mid_pre_%0d wr_en=%b data=%h exp=1/%h", k, ifc.wr_en, ifc.data_in, 8'(k)); end
      advance();
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ifc.wr_en !== 1'b0 || ifc.req_ready !== 4'b0000) begin failures++; $display("FAIL mid_rst_cycle wr_en=%b ready=%b exp=0/0000", ifc.wr_en, ifc.req_ready); end
    advance();
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b0000 || ifc.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_state grant=%b busy=%b exp=0000/0", ifc.grant, ifc.busy); end
    rst = 1'b0;
    advance();
    @(negedge clk);
    checks++; if (ifc.grant !== 4'b0001 || ifc.data_in !== 8'h02) begin failures++; $display("FAIL mid_restart grant=%b data=%h exp=0001/02", ifc.grant, ifc.data_in); end
    ifc.req_valid = '0;
  endtask

  initial begin
    ifc.req_valid = '0;
    ifc.f_full = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = '0;
    test_reset();
    test_round_robin();
    test_single_req();
    test_full_stall();
    test_owner_drop();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
